bubble_page_sequencer: RTL and testbench

- Sequences page fetches for the bubble emulator read path. Tracks the emulated bubble loop position from the host's shift-enable pulses.
- On each replicator pulse, issues one page-load request to the SPI flash page loader. The request is for either the bootloader area (boot-loop mode) or the user page at the current position.
- Sits between the host-side control inputs (nBSEN/nREPEN/nBOOTEN, synchronised here) and the flash loader. Also drives the access LED.

---
 rtl/bubble_page_sequencer.sv | 218 +++++++++++++++++++++
 tb/tb_bubble_page_sequencer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bubble_page_sequencer.sv
// Page-fetch sequencer for the bubble emulator read path: tracks the loop position
// from host shift pulses and issues one flash page-load request per replicate pulse.
module bubble_page_sequencer #(
    parameter int POS_MAX    = 2052,
    parameter int REP_OFFSET = 1,
    parameter int BOOT_PAGES = 12,
    parameter int LED_HOLD   = 24000
) (
    input  logic        MCLK,
    input  logic        MRST,
    input  logic        ROT_TICK,
    input  logic        nBSEN,
    input  logic        nREPEN,
    input  logic        nBOOTEN,
    output logic        LOAD_REQ,
    output logic        LOAD_BOOT,
    output logic [11:0] LOAD_PAGE,
    input  logic        LOAD_ACK,
    input  logic        LOAD_DONE,
    output logic [11:0] BPOS,
    output logic        OVERRUN,
    output logic        nLED_ACC
);

    localparam int LED_W  = $clog2(LED_HOLD + 1);
    localparam int BOOT_W = $clog2(BOOT_PAGES + 1);

    localparam logic [12:0]       POS_MAX_W  = 13'(POS_MAX);
    localparam logic [12:0]       POS_MOD_W  = 13'(POS_MAX + 1);
    localparam logic [12:0]       REP_OFF_W  = 13'(REP_OFFSET);
    localparam logic [BOOT_W-1:0] BOOT_LAST  = BOOT_W'(BOOT_PAGES - 1);
    localparam logic [LED_W-1:0]  LED_HOLD_W = LED_W'(LED_HOLD);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_BUSY = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic bsen_meta_q, bsen_meta_d, bsen_sync_q, bsen_sync_d;
    logic rep_meta_q, rep_meta_d, rep_sync_q, rep_sync_d, rep_prev_q, rep_prev_d;
    logic rep_evt_q, rep_evt_d;
    logic boot_meta_q, boot_meta_d, boot_sync_q, boot_sync_d, boot_prev_q, boot_prev_d;

    logic [11:0]       bpos_q, bpos_d;
    logic [BOOT_W-1:0] boot_idx_q, boot_idx_d;
    logic              pend_valid_q, pend_valid_d;
    logic              pend_boot_q, pend_boot_d;
    logic [11:0]       pend_page_q, pend_page_d;
    logic              load_req_q, load_req_d;
    logic              load_boot_q, load_boot_d;
    logic [11:0]       load_page_q, load_page_d;
    logic              overrun_q, overrun_d;
    logic [LED_W-1:0]  led_cnt_q, led_cnt_d;
    logic              nled_q, nled_d;

    logic              boot_mode, boot_fall, evt_taken;
    logic [12:0]       user_sum;
    logic [11:0]       user_page, cap_page;
    logic [BOOT_W-1:0] boot_idx_eff;

    // Handshake: LOAD_REQ rises with LOAD_BOOT/LOAD_PAGE valid and holds them stable
    // until the loader pulses LOAD_ACK; the page is then owned by the loader until LOAD_DONE.
    always_comb begin
        bsen_meta_d = nBSEN;
        bsen_sync_d = bsen_meta_q;
        rep_meta_d  = nREPEN;
        rep_sync_d  = rep_meta_q;
        rep_prev_d  = rep_sync_q;
        rep_evt_d   = rep_prev_q & ~rep_sync_q;
        boot_meta_d = nBOOTEN;
        boot_sync_d = boot_meta_q;
        boot_prev_d = boot_sync_q;

        boot_mode = ~boot_sync_q;
        boot_fall = boot_prev_q & ~boot_sync_q;

        user_sum  = {1'b0, bpos_q} + REP_OFF_W;
        user_page = (user_sum > POS_MAX_W) ? 12'(user_sum - POS_MOD_W) : user_sum[11:0];
        boot_idx_eff = boot_fall ? '0 : boot_idx_q;
        cap_page  = boot_mode ? 12'(boot_idx_eff) : user_page;

        if (boot_mode)
            bpos_d = '0;
        else if (ROT_TICK && !bsen_sync_q)
            bpos_d = (bpos_q == POS_MAX_W[11:0]) ? 12'd0 : bpos_q + 12'd1;
        else
            bpos_d = bpos_q;

        state_d      = state_q;
        pend_valid_d = pend_valid_q;
        pend_boot_d  = pend_boot_q;
        pend_page_d  = pend_page_q;
        load_req_d   = load_req_q;
        load_boot_d  = load_boot_q;
        load_page_d  = load_page_q;
        overrun_d    = overrun_q;
        evt_taken    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pend_valid_q) begin
                    state_d      = ST_REQ;
                    load_req_d   = 1'b1;
                    load_boot_d  = pend_boot_q;
                    load_page_d  = pend_page_q;
                    pend_valid_d = 1'b0;
                    // The slot empties this cycle, so a simultaneous event refills it.
                    if (rep_evt_q) begin
                        pend_valid_d = 1'b1;
                        pend_boot_d  = boot_mode;
                        pend_page_d  = cap_page;
                        evt_taken    = 1'b1;
                    end
                end else if (rep_evt_q) begin
                    state_d     = ST_REQ;
                    load_req_d  = 1'b1;
                    load_boot_d = boot_mode;
                    load_page_d = cap_page;
                    evt_taken   = 1'b1;
                end
            end
            ST_REQ, ST_BUSY: begin
                if (state_q == ST_REQ && LOAD_ACK) begin
                    state_d    = ST_BUSY;
                    load_req_d = 1'b0;
                end else if (state_q == ST_BUSY && LOAD_DONE) begin
                    state_d = ST_IDLE;
                end
                if (rep_evt_q) begin
                    if (!pend_valid_q) begin
                        pend_valid_d = 1'b1;
                        pend_boot_d  = boot_mode;
                        pend_page_d  = cap_page;
                        evt_taken    = 1'b1;
                    end else begin
                        overrun_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d    = ST_IDLE;
                load_req_d = 1'b0;
            end
        endcase

        boot_idx_d = boot_idx_eff;
        if (evt_taken && boot_mode)
            boot_idx_d = (boot_idx_eff == BOOT_LAST) ? '0 : boot_idx_eff + BOOT_W'(1);

        // Counter sits at LED_HOLD while busy, so it starts the hold window on entry to IDLE.
        if (state_q != ST_IDLE)
            led_cnt_d = LED_HOLD_W;
        else if (led_cnt_q != '0)
            led_cnt_d = led_cnt_q - LED_W'(1);
        else
            led_cnt_d = '0;
        nled_d = (state_d == ST_IDLE) && (led_cnt_d == '0);
    end

    always_ff @(posedge MCLK) begin
        if (!MRST) begin
            state_q      <= ST_IDLE;
            bsen_meta_q  <= 1'b1;
            bsen_sync_q  <= 1'b1;
            rep_meta_q   <= 1'b1;
            rep_sync_q   <= 1'b1;
            rep_prev_q   <= 1'b1;
            rep_evt_q    <= 1'b0;
            boot_meta_q  <= 1'b1;
            boot_sync_q  <= 1'b1;
            boot_prev_q  <= 1'b1;
            bpos_q       <= '0;
            boot_idx_q   <= '0;
            pend_valid_q <= 1'b0;
            pend_boot_q  <= 1'b0;
            pend_page_q  <= '0;
            load_req_q   <= 1'b0;
            load_boot_q  <= 1'b0;
            load_page_q  <= '0;
            overrun_q    <= 1'b0;
            led_cnt_q    <= '0;
            nled_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            bsen_meta_q  <= bsen_meta_d;
            bsen_sync_q  <= bsen_sync_d;
            rep_meta_q   <= rep_meta_d;
            rep_sync_q   <= rep_sync_d;
            rep_prev_q   <= rep_prev_d;
            rep_evt_q    <= rep_evt_d;
            boot_meta_q  <= boot_meta_d;
            boot_sync_q  <= boot_sync_d;
            boot_prev_q  <= boot_prev_d;
            bpos_q       <= bpos_d;
            boot_idx_q   <= boot_idx_d;
            pend_valid_q <= pend_valid_d;
            pend_boot_q  <= pend_boot_d;
            pend_page_q  <= pend_page_d;
            load_req_q   <= load_req_d;
            load_boot_q  <= load_boot_d;
            load_page_q  <= load_page_d;
            overrun_q    <= overrun_d;
            led_cnt_q    <= led_cnt_d;
            nled_q       <= nled_d;
        end
    end

    assign LOAD_REQ  = load_req_q;
    assign LOAD_BOOT = load_boot_q;
    assign LOAD_PAGE = load_page_q;
    assign BPOS      = bpos_q;
    assign OVERRUN   = overrun_q;
    assign nLED_ACC  = nled_q;

endmodule

// File: tb/tb_bubble_page_sequencer.sv
// Directed bench for bubble_page_sequencer: position counting, boot/user page
// requests, pending slot and overrun, mid-request reset and LED hold time.
module tb_bubble_page_sequencer;

    logic        MCLK = 1'b0;
    logic        MRST;
    logic        ROT_TICK;
    logic        nBSEN;
    logic        nREPEN;
    logic        nBOOTEN;
    logic        LOAD_REQ;
    logic        LOAD_BOOT;
    logic [11:0] LOAD_PAGE;
    logic        LOAD_ACK;
    logic        LOAD_DONE;
    logic [11:0] BPOS;
    logic        OVERRUN;
    logic        nLED_ACC;

    int n_checks = 0;
    int n_errors = 0;

    bubble_page_sequencer dut (
        .MCLK      (MCLK),
        .MRST      (MRST),
        .ROT_TICK  (ROT_TICK),
        .nBSEN     (nBSEN),
        .nREPEN    (nREPEN),
        .nBOOTEN   (nBOOTEN),
        .LOAD_REQ  (LOAD_REQ),
        .LOAD_BOOT (LOAD_BOOT),
        .LOAD_PAGE (LOAD_PAGE),
        .LOAD_ACK  (LOAD_ACK),
        .LOAD_DONE (LOAD_DONE),
        .BPOS      (BPOS),
        .OVERRUN   (OVERRUN),
        .nLED_ACC  (nLED_ACC)
    );

    always #5 MCLK = ~MCLK;

    task automatic tick();
        @(posedge MCLK);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drops nREPEN and counts edges until LOAD_REQ is seen (bounded).
    task automatic rep_to_req(output int lat);
        nREPEN = 1'b0;
        lat = 0;
        while (lat < 20) begin
            tick();
            lat++;
            if (LOAD_REQ) break;
        end
        nREPEN = 1'b1;
    endtask

    // A replicate pulse with no wait on the request; leaves the synchroniser idle again.
    task automatic rep_pulse_only();
        nREPEN = 1'b0;
        ticks(4);
        nREPEN = 1'b1;
        ticks(4);
    endtask

    task automatic finish_txn(input string tag);
        LOAD_ACK = 1'b1;
        tick();
        LOAD_ACK = 1'b0;
        check_eq({tag, "_req_drop"}, LOAD_REQ, 1'b0);
        ticks(2);
        LOAD_DONE = 1'b1;
        tick();
        LOAD_DONE = 1'b0;
    endtask

    task automatic rot_ticks(input int n);
        ROT_TICK = 1'b1;
        ticks(n);
        ROT_TICK = 1'b0;
    endtask

    int   lat;
    int   exp_pos;
    int   led_cnt;
    logic led_all_high;

    initial begin
        MRST = 1'b0; ROT_TICK = 1'b0; nBSEN = 1'b1; nREPEN = 1'b1; nBOOTEN = 1'b1;
        LOAD_ACK = 1'b0; LOAD_DONE = 1'b0;
        ticks(3);
        check_eq("rst_req", LOAD_REQ, 1'b0);
        check_eq("rst_boot", LOAD_BOOT, 1'b0);
        check_eq("rst_page", LOAD_PAGE, 12'd0);
        check_eq("rst_bpos", BPOS, 12'd0);
        check_eq("rst_ovr", OVERRUN, 1'b0);
        check_eq("rst_led", nLED_ACC, 1'b1);
        MRST = 1'b1;
        tick();

        // Position counter through the wrap.
        nBSEN = 1'b0;
        ticks(3);
        exp_pos = 0;
        led_all_high = 1'b1;
        ROT_TICK = 1'b1;
        for (int i = 0; i < 2060; i++) begin
            tick();
            exp_pos = (exp_pos == 2052) ? 0 : exp_pos + 1;
            check_eq("bpos_count", BPOS, exp_pos[11:0]);
            led_all_high = led_all_high & nLED_ACC;
        end
        ROT_TICK = 1'b0;
        check_eq("bpos_end", BPOS, 12'd7);
        check_eq("led_idle", led_all_high, 1'b1);

        nBSEN = 1'b1;
        ticks(3);
        rot_ticks(5);
        check_eq("bpos_hold", BPOS, 12'd7);

        // Boot-loop requests.
        nBOOTEN = 1'b0;
        ticks(4);
        check_eq("bpos_boot_zero", BPOS, 12'd0);
        for (int k = 0; k < 3; k++) begin
            rep_to_req(lat);
            if (k == 0) check_eq("boot_latency", lat, 4);
            check_eq("boot_req", LOAD_REQ, 1'b1);
            check_eq("boot_flag", LOAD_BOOT, 1'b1);
            check_eq("boot_page", LOAD_PAGE, k[11:0]);
            check_eq("boot_led_busy", nLED_ACC, 1'b0);
            finish_txn("boot");
            ticks(3);
        end

        // User page at the top of the loop wraps to 0.
        nBOOTEN = 1'b1;
        nBSEN = 1'b0;
        ticks(4);
        rot_ticks(2052);
        nBSEN = 1'b1;
        ticks(3);
        check_eq("bpos_top", BPOS, 12'd2052);
        rep_to_req(lat);
        check_eq("user_latency", lat, 4);
        check_eq("user_wrap_boot", LOAD_BOOT, 1'b0);
        check_eq("user_wrap_page", LOAD_PAGE, 12'd0);
        finish_txn("user_wrap");
        ticks(3);

        // BPOS=100 with a tick in the capture cycle: pre-increment position is used.
        nBSEN = 1'b0;
        ticks(3);
        rot_ticks(101);
        check_eq("bpos_100", BPOS, 12'd100);
        nREPEN = 1'b0;
        ticks(3);
        check_eq("user_req_early", LOAD_REQ, 1'b0);
        ROT_TICK = 1'b1;
        tick();
        ROT_TICK = 1'b0;
        nREPEN = 1'b1;
        check_eq("user_req", LOAD_REQ, 1'b1);
        check_eq("user_page", LOAD_PAGE, 12'd101);
        check_eq("user_boot", LOAD_BOOT, 1'b0);
        check_eq("bpos_101", BPOS, 12'd101);
        nBSEN = 1'b1;
        ticks(6);
        check_eq("user_req_held", LOAD_REQ, 1'b1);
        check_eq("user_page_held", LOAD_PAGE, 12'd101);
        finish_txn("user");
        ticks(3);

        // Pending slot and overrun with ACK withheld.
        rep_pulse_only();
        check_eq("ovr_req1", LOAD_REQ, 1'b1);
        check_eq("ovr_page1", LOAD_PAGE, 12'd102);
        nBSEN = 1'b0;
        ticks(3);
        rot_ticks(5);
        rep_pulse_only();
        check_eq("ovr_no_flag", OVERRUN, 1'b0);
        rot_ticks(2);
        rep_pulse_only();
        check_eq("ovr_flag", OVERRUN, 1'b1);
        check_eq("ovr_page_stable", LOAD_PAGE, 12'd102);
        LOAD_ACK = 1'b1;
        tick();
        LOAD_ACK = 1'b0;
        ticks(2);
        LOAD_DONE = 1'b1;
        tick();
        LOAD_DONE = 1'b0;
        check_eq("ovr_gap", LOAD_REQ, 1'b0);
        tick();
        check_eq("ovr_req2", LOAD_REQ, 1'b1);
        check_eq("ovr_page2", LOAD_PAGE, 12'd107);
        finish_txn("ovr2");
        ticks(4);
        check_eq("ovr_third_dropped", LOAD_REQ, 1'b0);
        check_eq("ovr_sticky", OVERRUN, 1'b1);

        // Reset while in REQ; a late ACK/DONE is ignored.
        rep_to_req(lat);
        check_eq("rreq_req", LOAD_REQ, 1'b1);
        check_eq("rreq_page", LOAD_PAGE, 12'd109);
        MRST = 1'b0;
        tick();
        check_eq("rreq_req_drop", LOAD_REQ, 1'b0);
        check_eq("rreq_bpos", BPOS, 12'd0);
        check_eq("rreq_ovr", OVERRUN, 1'b0);
        check_eq("rreq_led", nLED_ACC, 1'b1);
        MRST = 1'b1;
        LOAD_ACK = 1'b1;
        tick();
        LOAD_ACK = 1'b0;
        LOAD_DONE = 1'b1;
        tick();
        LOAD_DONE = 1'b0;
        ticks(2);
        check_eq("rreq_late_req", LOAD_REQ, 1'b0);
        check_eq("rreq_late_led", nLED_ACC, 1'b1);

        // LED hold after DONE.
        rep_to_req(lat);
        check_eq("led_req_page", LOAD_PAGE, 12'd1);
        LOAD_ACK = 1'b1;
        tick();
        LOAD_ACK = 1'b0;
        tick();
        LOAD_DONE = 1'b1;
        tick();
        LOAD_DONE = 1'b0;
        led_cnt = 0;
        while (led_cnt < 30000 && nLED_ACC == 1'b0) begin
            led_cnt++;
            tick();
        end
        check_eq("led_hold", led_cnt, 24000);
        check_eq("led_off", nLED_ACC, 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
